// File: rtl/leak_rmc_input_filter_pkg.sv
// -----------------------------------------------------------------------------
// leak_rmc_input_filter_pkg
//
// Purpose:
//   Shared definitions for the leak / RMC input conditioning stage that feeds
//   the master power sequencer. It holds the debounce state codes, the default
//   timing parameters, the oStatus bit positions and a small decode helper.
//
// Contents:
//   deb_state_e         2-bit debounce FSM state code (also exported on debug)
//   *_DEF localparams   default prescaler / debounce / pulse settings
//   DEB_CNT_W           width of the per-channel debounce counter
//   ST_* localparams    oStatus sticky bit indices
//   deb_level()         filtered level implied by a debounce state
// -----------------------------------------------------------------------------
package leak_rmc_input_filter_pkg;

    // The code values are visible on oDBG_Deb_State, so they are fixed here.
    // Bit [1] is 0 on the "high" side (STABLE_HI, PEND_LO) and 1 on the
    // "low" side (STABLE_LO, PEND_HI).
    typedef enum logic [1:0] {
        DEB_STABLE_HI = 2'd0,
        DEB_PEND_LO   = 2'd1,
        DEB_STABLE_LO = 2'd2,
        DEB_PEND_HI   = 2'd3
    } deb_state_e;

    localparam int unsigned CLK_PER_MS_DEF    = 2000; // 2 MHz clock -> 1 ms
    localparam int unsigned LEAK_DEB_MS_DEF   = 10;
    localparam int unsigned RMC_DEB_MS_DEF    = 20;
    localparam int unsigned CLR_PULSE_CYC_DEF = 4;

    localparam int DEB_CNT_W = 16;

    localparam int ST_LARGE_SEEN = 0;
    localparam int ST_SMALL_SEEN = 1;
    localparam int ST_RMC_LOST   = 2;
    localparam int ST_CLR_REJECT = 3;

    // While pending, the filtered level still holds the old stable value.
    function automatic logic deb_level(input deb_state_e s);
        return (s == DEB_STABLE_HI) || (s == DEB_PEND_LO);
    endfunction

endpackage

// File: rtl/leak_rmc_input_filter_debounce_ms.sv
// -----------------------------------------------------------------------------
// debounce_ms
//
// Purpose:
//   One input conditioning channel: a 2-FF synchronizer followed by a 4-state
//   debounce FSM that only lets the filtered level follow a new raw level once
//   it has held for DEB_MS millisecond ticks.
//
// Parameters:
//   DEB_MS       number of ms ticks a new level must hold
//   RESET_LEVEL  level of the synchronizer and filtered output in reset
//
// Ports:
//   iClk       in   module clock
//   iRst_n     in   asynchronous active-low reset
//   i_ms_tick  in   1-cycle pulse once per millisecond
//   i_raw      in   raw asynchronous input
//   o_filt     out  debounced level
//   o_state    out  current debounce state code (deb_state_e)
// -----------------------------------------------------------------------------
module debounce_ms
    import leak_rmc_input_filter_pkg::*;
#(
    parameter int unsigned DEB_MS      = LEAK_DEB_MS_DEF,
    parameter logic        RESET_LEVEL = 1'b1
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       i_ms_tick,
    input  logic       i_raw,
    output logic       o_filt,
    output logic [1:0] o_state
);

    localparam deb_state_e            RST_STATE = RESET_LEVEL ? DEB_STABLE_HI : DEB_STABLE_LO;
    localparam logic [DEB_CNT_W-1:0]  DEB_LIMIT = DEB_CNT_W'(DEB_MS);

    logic                 r_sync1;
    logic                 r_sync2;
    deb_state_e           r_state;
    deb_state_e           w_state_nxt;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic [DEB_CNT_W-1:0] w_cnt_nxt;
    logic [DEB_CNT_W-1:0] w_cnt_inc;

    // Synchronizer resets to the channel's idle level so that reset release
    // does not look like an edge on an input that is sitting at idle.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Saturating increment: a huge DEB_MS must never see the counter wrap.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // A level return while pending takes priority over a tick in the same
    // cycle. The tick that completes the count moves straight to the new
    // stable state, so the filtered level flips on that edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            DEB_STABLE_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = DEB_PEND_LO;
                    w_cnt_nxt   = '0;
                end
            end
            DEB_PEND_LO: begin
                if (r_sync2) begin
                    w_state_nxt = DEB_STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (i_ms_tick) begin
                    if (w_cnt_inc >= DEB_LIMIT) begin
                        w_state_nxt = DEB_STABLE_LO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            DEB_STABLE_LO: begin
                if (r_sync2) begin
                    w_state_nxt = DEB_PEND_HI;
                    w_cnt_nxt   = '0;
                end
            end
            DEB_PEND_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = DEB_STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (i_ms_tick) begin
                    if (w_cnt_inc >= DEB_LIMIT) begin
                        w_state_nxt = DEB_STABLE_HI;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Decoded from the state register alone (a single bit), so it is glitch-free.
    assign o_filt  = deb_level(r_state);
    assign o_state = r_state;

endmodule

// File: rtl/leak_rmc_input_filter.sv
// -----------------------------------------------------------------------------
// leak_rmc_input_filter
//
// Purpose:
//   Conditioning stage in front of the master power sequencer. Debounces the
//   raw large-leak, small-leak and RMC power-enable inputs against a 1 ms
//   tick, latches the large leak, keeps sticky status bits and turns a BMC
//   clear request into a fixed-width latch-clear pulse.
//
// Ports:
//   iClk                  in   module clock (2 MHz)
//   iRst_n                in   asynchronous active-low reset
//   iLarge_Leak_N_raw     in   raw large-leak detect, active-low, async
//   iSmall_Leak_N_raw     in   raw small-leak detect, active-low, async
//   iRMC_PWR_Enable_raw   in   raw rack power enable, async
//   iBMC_Clear            in   BMC clear request level, sync to iClk
//   oLarge_Leak_Detect_N  out  filtered + latched large leak, active-low
//   oSmall_Leak_Detect_N  out  filtered small leak, active-low, not latched
//   oRMC_PWR_Enable       out  filtered RMC enable
//   oLatch_Clear          out  clear pulse to the sequencer
//   oStatus[3:0]          out  sticky: large seen, small seen, RMC lost,
//                              clear rejected
//   oDBG_Deb_State[5:0]   out  debounce states: [1:0] large, [3:2] small,
//                              [5:4] RMC
// -----------------------------------------------------------------------------
module leak_rmc_input_filter
    import leak_rmc_input_filter_pkg::*;
#(
    parameter int unsigned CLK_PER_MS    = CLK_PER_MS_DEF,
    parameter int unsigned LEAK_DEB_MS   = LEAK_DEB_MS_DEF,
    parameter int unsigned RMC_DEB_MS    = RMC_DEB_MS_DEF,
    parameter int unsigned CLR_PULSE_CYC = CLR_PULSE_CYC_DEF
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iLarge_Leak_N_raw,
    input  logic       iSmall_Leak_N_raw,
    input  logic       iRMC_PWR_Enable_raw,
    input  logic       iBMC_Clear,
    output logic       oLarge_Leak_Detect_N,
    output logic       oSmall_Leak_Detect_N,
    output logic       oRMC_PWR_Enable,
    output logic       oLatch_Clear,
    output logic [3:0] oStatus,
    output logic [5:0] oDBG_Deb_State
);

    localparam int PRESC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);
    localparam int PULSE_W = $clog2(CLR_PULSE_CYC + 1);
    localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(CLR_PULSE_CYC);

    // ---------------------------------------------------------------------
    // Millisecond prescaler
    // ---------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc;
    logic               w_ms_tick;

    assign w_ms_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_presc <= '0;
        end else if (w_ms_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Debounce channels
    // ---------------------------------------------------------------------
    logic       w_filt_large;
    logic       w_filt_small;
    logic       w_filt_rmc;
    logic [1:0] w_st_large;
    logic [1:0] w_st_small;
    logic [1:0] w_st_rmc;

    debounce_ms #(
        .DEB_MS      (LEAK_DEB_MS),
        .RESET_LEVEL (1'b1)
    ) u_deb_large (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .i_ms_tick (w_ms_tick),
        .i_raw     (iLarge_Leak_N_raw),
        .o_filt    (w_filt_large),
        .o_state   (w_st_large)
    );

    debounce_ms #(
        .DEB_MS      (LEAK_DEB_MS),
        .RESET_LEVEL (1'b1)
    ) u_deb_small (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .i_ms_tick (w_ms_tick),
        .i_raw     (iSmall_Leak_N_raw),
        .o_filt    (w_filt_small),
        .o_state   (w_st_small)
    );

    debounce_ms #(
        .DEB_MS      (RMC_DEB_MS),
        .RESET_LEVEL (1'b0)
    ) u_deb_rmc (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .i_ms_tick (w_ms_tick),
        .i_raw     (iRMC_PWR_Enable_raw),
        .o_filt    (w_filt_rmc),
        .o_state   (w_st_rmc)
    );

    // ---------------------------------------------------------------------
    // Event detection, latch, status and clear handshake
    //
    // Clear handshake: the request is the registered rising edge of
    // iBMC_Clear, alive for exactly one cycle (r_clr_req). In that cycle it
    // is either accepted (filtered large leak and RMC enable both high, no
    // pulse running), rejected (either filtered level low, no pulse running)
    // or dropped (pulse already running). Accept clears the latch and status
    // and loads the pulse counter, so oLatch_Clear is high for CLR_PULSE_CYC
    // cycles starting on the next cycle. A level held high is one request.
    // ---------------------------------------------------------------------
    logic               r_small_prev;
    logic               r_rmc_prev;
    logic               r_clr_prev;
    logic               r_clr_req;
    logic               r_large_latch;
    logic [3:0]         r_status;
    logic [PULSE_W-1:0] r_pulse_cnt;

    logic               w_large_set;
    logic               w_small_fall;
    logic               w_rmc_fall;
    logic               w_clr_rise;
    logic               w_pulse_active;
    logic               w_clr_ok;
    logic               w_clr_accept;
    logic               w_clr_reject;
    logic               w_latch_nxt;
    logic [3:0]         w_status_nxt;
    logic [PULSE_W-1:0] w_pulse_nxt;

    assign w_large_set    = ~w_filt_large;
    assign w_small_fall   = r_small_prev & ~w_filt_small;
    assign w_rmc_fall     = r_rmc_prev & ~w_filt_rmc;
    assign w_clr_rise     = iBMC_Clear & ~r_clr_prev;
    assign w_pulse_active = (r_pulse_cnt != '0);
    assign w_clr_ok       = w_filt_large & w_filt_rmc;
    assign w_clr_accept   = r_clr_req & ~w_pulse_active & w_clr_ok;
    assign w_clr_reject   = r_clr_req & ~w_pulse_active & ~w_clr_ok;

    // Clears are applied first and events afterwards, so an event arriving
    // in the same cycle as an accepted clear leaves its bit set.
    always_comb begin
        w_latch_nxt  = r_large_latch;
        w_status_nxt = r_status;
        w_pulse_nxt  = r_pulse_cnt;

        if (w_clr_accept) begin
            w_latch_nxt  = 1'b0;
            w_status_nxt = 4'b0000;
            w_pulse_nxt  = PULSE_LOAD;
        end else if (w_pulse_active) begin
            w_pulse_nxt  = r_pulse_cnt - 1'b1;
        end

        if (w_clr_reject) begin
            w_status_nxt[ST_CLR_REJECT] = 1'b1;
        end
        if (w_large_set) begin
            w_latch_nxt                 = 1'b1;
            w_status_nxt[ST_LARGE_SEEN] = 1'b1;
        end
        if (w_small_fall) begin
            w_status_nxt[ST_SMALL_SEEN] = 1'b1;
        end
        if (w_rmc_fall) begin
            w_status_nxt[ST_RMC_LOST]   = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_small_prev  <= 1'b1;
            r_rmc_prev    <= 1'b0;
            r_clr_prev    <= 1'b0;
            r_clr_req     <= 1'b0;
            r_large_latch <= 1'b0;
            r_status      <= 4'b0000;
            r_pulse_cnt   <= '0;
        end else begin
            r_small_prev  <= w_filt_small;
            r_rmc_prev    <= w_filt_rmc;
            r_clr_prev    <= iBMC_Clear;
            r_clr_req     <= w_clr_rise;
            r_large_latch <= w_latch_nxt;
            r_status      <= w_status_nxt;
            r_pulse_cnt   <= w_pulse_nxt;
        end
    end

    // The filtered term makes the large output fall on the same edge the
    // debounce completes; the latch then holds it low afterwards.
    assign oLarge_Leak_Detect_N = ~(r_large_latch | ~w_filt_large);
    assign oSmall_Leak_Detect_N = w_filt_small;
    assign oRMC_PWR_Enable      = w_filt_rmc;
    assign oLatch_Clear         = w_pulse_active;
    assign oStatus              = r_status;
    assign oDBG_Deb_State       = {w_st_rmc, w_st_small, w_st_large};

endmodule
